hockey_match_ctrl: RTL and testbench

// Match sequencer above the hockey game core. Edge-detects BTN_A/BTN_B and forwards presses to the core

---
 rtl/hockey_pkg.sv | 26 ++
 rtl/btn_edge.sv | 26 ++
 rtl/hockey_match_ctrl.sv | 154 +++++++++++++++
 tb/tb_hockey_match_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hockey_pkg.sv
// ============================================================================
// Module : hockey_pkg
// Brief  : Shared state encoding, player encoding and defaults for the match
//          controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hockey_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE_A   = 3'd1,
        ST_SERVE_B   = 3'd2,
        ST_RALLY     = 3'd3,
        ST_GOAL_HOLD = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam logic PLAYER_A      = 1'b0;
    localparam logic PLAYER_B      = 1'b1;
    localparam int   WIN_SCORE_DEF = 3;

endpackage

`default_nettype wire

// File: rtl/btn_edge.sv
// ============================================================================
// Module : btn_edge
// Brief  : Rising-edge detector for an already-synchronised button level.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= 1'b0;
        else     r_q <= btn;
    end

    assign rise = btn & ~r_q;

endmodule

`default_nettype wire

// File: rtl/hockey_match_ctrl.sv
// ============================================================================
// Module : hockey_match_ctrl
// Brief  : Match sequencer: gates button presses to the game core, keeps
//          score, chooses the server and declares the winner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hockey_match_ctrl
    import hockey_pkg::*;
#(
    parameter  int WIN_SCORE = WIN_SCORE_DEF,
    parameter  int HOLD_CYC  = 4,
    parameter  int SERVE_TO  = 64,
    localparam int SW        = $clog2(WIN_SCORE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          BTN_A,
    input  logic          BTN_B,
    input  logic          goal_a,
    input  logic          goal_b,
    output logic          core_rst,
    output logic          core_btn_a,
    output logic          core_btn_b,
    output logic [SW-1:0] score_a,
    output logic [SW-1:0] score_b,
    output logic          server,
    output logic [2:0]    state_o,
    output logic          game_over,
    output logic          winner,
    output logic          protocol_err
);

    localparam int CNT_MAX = (HOLD_CYC > SERVE_TO) ? HOLD_CYC : SERVE_TO;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_core_rst, r_btn_a, r_btn_b, r_server, r_winner, r_game_over, r_perr;
    logic [SW-1:0]   r_score_a, r_score_b;
    logic            w_rise_a, w_rise_b, w_serve_to, w_hold_done;

    btn_edge u_edge_a (.clk(clk), .rst(rst), .btn(BTN_A), .rise(w_rise_a));
    btn_edge u_edge_b (.clk(clk), .rst(rst), .btn(BTN_B), .rise(w_rise_b));

    // One counter serves both the serve timeout and the goal hold; it is zeroed on every state change.
    assign w_serve_to  = (SERVE_TO != 0) && (r_cnt == CW'(SERVE_TO - 1));
    assign w_hold_done = (r_cnt == CW'(HOLD_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_core_rst  <= 1'b1;
            r_btn_a     <= 1'b0;
            r_btn_b     <= 1'b0;
            r_score_a   <= '0;
            r_score_b   <= '0;
            r_server    <= PLAYER_A;
            r_winner    <= PLAYER_A;
            r_game_over <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            r_btn_a <= 1'b0;
            r_btn_b <= 1'b0;
            r_cnt   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise_a) begin
                        r_state    <= ST_SERVE_A;
                        r_server   <= PLAYER_A;
                        r_core_rst <= 1'b0;
                    end else if (w_rise_b) begin
                        r_state    <= ST_SERVE_B;
                        r_server   <= PLAYER_B;
                        r_core_rst <= 1'b0;
                    end
                end
                ST_SERVE_A: begin
                    if (w_rise_a || w_serve_to) begin
                        r_btn_a <= 1'b1;
                        r_state <= ST_RALLY;
                    end else if (SERVE_TO != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SERVE_B: begin
                    if (w_rise_b || w_serve_to) begin
                        r_btn_b <= 1'b1;
                        r_state <= ST_RALLY;
                    end else if (SERVE_TO != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RALLY: begin
                    r_btn_a <= w_rise_a;
                    r_btn_b <= w_rise_b;
                    if (goal_a && goal_b) begin
                        r_perr <= 1'b1;
                    end else if (goal_a) begin
                        if (r_score_a != SW'(WIN_SCORE)) r_score_a <= r_score_a + 1'b1;
                        r_server <= PLAYER_B;
                        r_state  <= ST_GOAL_HOLD;
                    end else if (goal_b) begin
                        if (r_score_b != SW'(WIN_SCORE)) r_score_b <= r_score_b + 1'b1;
                        r_server <= PLAYER_A;
                        r_state  <= ST_GOAL_HOLD;
                    end
                end
                ST_GOAL_HOLD: begin
                    if (!w_hold_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_score_a == SW'(WIN_SCORE) || r_score_b == SW'(WIN_SCORE)) begin
                        r_state     <= ST_GAME_OVER;
                        r_winner    <= (r_score_b == SW'(WIN_SCORE)) ? PLAYER_B : PLAYER_A;
                        r_game_over <= 1'b1;
                        r_core_rst  <= 1'b1;
                    end else begin
                        r_state <= (r_server == PLAYER_B) ? ST_SERVE_B : ST_SERVE_A;
                    end
                end
                ST_GAME_OVER: begin
                    if (BTN_A && BTN_B) begin
                        r_state     <= ST_IDLE;
                        r_score_a   <= '0;
                        r_score_b   <= '0;
                        r_winner    <= PLAYER_A;
                        r_server    <= PLAYER_A;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_core_rst <= 1'b1;
                end
            endcase
        end
    end

    assign core_rst     = r_core_rst;
    assign core_btn_a   = r_btn_a;
    assign core_btn_b   = r_btn_b;
    assign score_a      = r_score_a;
    assign score_b      = r_score_b;
    assign server       = r_server;
    assign state_o      = r_state;
    assign game_over    = r_game_over;
    assign winner       = r_winner;
    assign protocol_err = r_perr;

endmodule

`default_nettype wire

// File: tb/tb_hockey_match_ctrl.sv
// ============================================================================
// Module : tb_hockey_match_ctrl
// Brief  : Self-checking bench for hockey_match_ctrl against a match model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hockey_match_ctrl;

    localparam int WIN  = 3;
    localparam int HOLD = 4;
    localparam int STO  = 64;
    localparam int SW   = $clog2(WIN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1, BTN_A = 1'b0, BTN_B = 1'b0, goal_a = 1'b0, goal_b = 1'b0;
    logic          core_rst, core_btn_a, core_btn_b, server, game_over, winner, protocol_err;
    logic [SW-1:0] score_a, score_b;
    logic [2:0]    state_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hockey_match_ctrl #(.WIN_SCORE(WIN), .HOLD_CYC(HOLD), .SERVE_TO(STO)) dut (
        .clk(clk), .rst(rst), .BTN_A(BTN_A), .BTN_B(BTN_B), .goal_a(goal_a), .goal_b(goal_b),
        .core_rst(core_rst), .core_btn_a(core_btn_a), .core_btn_b(core_btn_b),
        .score_a(score_a), .score_b(score_b), .server(server), .state_o(state_o),
        .game_over(game_over), .winner(winner), .protocol_err(protocol_err)
    );

    // Match model: phase + countdown of remaining cycles, tracking the visible outputs.
    typedef struct {
        int   st;
        int   sa, sb;
        logic srv, win, perr, crst, cba, cbb;
        int   left;
        logic pa, pb;
    } model_t;

    model_t m;

    function automatic model_t step(model_t c, logic r, logic a, logic b, logic ga, logic gb);
        model_t n;
        logic   ra, rb, mine, fire;
        n = c;
        n.cba = 1'b0;
        n.cbb = 1'b0;
        if (r) begin
            n.st = 0; n.sa = 0; n.sb = 0; n.srv = 0; n.win = 0; n.perr = 0;
            n.crst = 1; n.left = 0; n.pa = 0; n.pb = 0;
            return n;
        end
        ra = a & ~c.pa;
        rb = b & ~c.pb;
        n.pa = a;
        n.pb = b;
        case (c.st)
            0: begin
                if (ra)      begin n.st = 1; n.srv = 0; n.left = STO; end
                else if (rb) begin n.st = 2; n.srv = 1; n.left = STO; end
            end
            1, 2: begin
                mine = (c.st == 1) ? ra : rb;
                fire = mine;
                if (!mine && STO != 0) begin
                    n.left = c.left - 1;
                    fire   = (n.left == 0);
                end
                if (fire) begin
                    n.st = 3;
                    if (c.st == 1) n.cba = 1'b1;
                    else           n.cbb = 1'b1;
                end
            end
            3: begin
                n.cba = ra;
                n.cbb = rb;
                if (ga && gb) n.perr = 1'b1;
                else if (ga) begin n.sa = (c.sa < WIN) ? c.sa + 1 : WIN; n.srv = 1; n.st = 4; n.left = HOLD; end
                else if (gb) begin n.sb = (c.sb < WIN) ? c.sb + 1 : WIN; n.srv = 0; n.st = 4; n.left = HOLD; end
            end
            4: begin
                n.left = c.left - 1;
                if (n.left == 0) begin
                    if (c.sa == WIN || c.sb == WIN) begin
                        n.st  = 5;
                        n.win = (c.sb == WIN);
                    end else begin
                        n.st   = c.srv ? 2 : 1;
                        n.left = STO;
                    end
                end
            end
            5: begin
                if (a && b) begin n.st = 0; n.sa = 0; n.sb = 0; n.win = 0; n.srv = 0; end
            end
            default: n.st = 0;
        endcase
        n.crst = (n.st == 0 || n.st == 5);
        return n;
    endfunction

    always @(posedge clk) m <= step(m, rst, BTN_A, BTN_B, goal_a, goal_b);

    always @(negedge clk) begin
        logic [13:0] got, exp;
        if (chk_en) begin
            got = {state_o, score_a, score_b, server, core_rst, core_btn_a, core_btn_b,
                   game_over, winner, protocol_err};
            exp = {3'(m.st), SW'(m.sa), SW'(m.sb), m.srv, m.crst, m.cba, m.cbb,
                   (m.st == 5), m.win, m.perr};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL model @%0t: got %b expected %b", $time, got, exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Called at a falling edge: apply inputs for one cycle, return at the next falling edge.
    task automatic cyc(input logic r, input logic a, input logic b, input logic ga, input logic gb);
        rst = r; BTN_A = a; BTN_B = b; goal_a = ga; goal_b = gb;
        @(negedge clk);
    endtask

    task automatic wait_state(input int tgt, input int budget);
        int i;
        i = 0;
        while (state_o != 3'(tgt) && i < budget) begin
            cyc(0, 0, 0, 0, 0);
            i++;
        end
        check("wait_state", state_o, tgt);
    endtask

    typedef struct {
        logic r, a, b, ga, gb;
        int   st, sa, sb, srv, crst, cba, cbb;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int hit, pulses;
        //           r  a  b ga gb   st sa sb srv crst cba cbb
        tbl[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0,  1,   0,  0};
        tbl[1]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0,  1,   0,  0};
        tbl[2]  = '{0, 1, 0, 0, 0,   1, 0, 0, 0,  0,   0,  0};
        tbl[3]  = '{0, 0, 0, 0, 0,   1, 0, 0, 0,  0,   0,  0};
        tbl[4]  = '{0, 1, 0, 0, 0,   3, 0, 0, 0,  0,   1,  0};
        tbl[5]  = '{0, 0, 0, 0, 0,   3, 0, 0, 0,  0,   0,  0};
        tbl[6]  = '{0, 0, 0, 1, 0,   4, 1, 0, 1,  0,   0,  0};
        tbl[7]  = '{0, 1, 0, 0, 0,   4, 1, 0, 1,  0,   0,  0};
        tbl[8]  = '{0, 0, 0, 0, 0,   4, 1, 0, 1,  0,   0,  0};
        tbl[9]  = '{0, 0, 0, 0, 0,   4, 1, 0, 1,  0,   0,  0};
        tbl[10] = '{0, 0, 0, 0, 0,   2, 1, 0, 1,  0,   0,  0};
        tbl[11] = '{0, 0, 1, 0, 0,   3, 1, 0, 1,  0,   0,  1};
        tbl[12] = '{0, 0, 0, 0, 0,   3, 1, 0, 1,  0,   0,  0};

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].ga, tbl[i].gb);
            chk_en = 1'b1;
            check($sformatf("tbl%0d state", i), state_o, tbl[i].st);
            check($sformatf("tbl%0d score_a", i), score_a, tbl[i].sa);
            check($sformatf("tbl%0d score_b", i), score_b, tbl[i].sb);
            check($sformatf("tbl%0d server", i), server, tbl[i].srv);
            check($sformatf("tbl%0d core_rst", i), core_rst, tbl[i].crst);
            check($sformatf("tbl%0d core_btn_a", i), core_btn_a, tbl[i].cba);
            check($sformatf("tbl%0d core_btn_b", i), core_btn_b, tbl[i].cbb);
        end

        // Simultaneous goals in a rally.
        cyc(0, 0, 0, 1, 1);
        check("dual goal perr", protocol_err, 1);
        check("dual goal state", state_o, 3);
        check("dual goal score_a", score_a, 1);
        check("dual goal score_b", score_b, 0);
        cyc(0, 0, 0, 0, 0);
        check("perr sticky", protocol_err, 1);
        cyc(1, 0, 0, 0, 0);
        check("perr cleared", protocol_err, 0);
        check("rst state", state_o, 0);

        // Serve timeout.
        cyc(0, 0, 1, 0, 0);
        check("serve_b state", state_o, 2);
        check("serve_b server", server, 1);
        check("serve_b core_rst", core_rst, 0);
        check("serve_b no fwd", core_btn_b, 0);
        hit = 0;
        for (int k = 1; k <= 200; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (core_btn_b) begin hit = k; break; end
        end
        check("serve timeout cycle", hit, STO);
        check("timeout state", state_o, 3);

        // B wins three rallies.
        for (int g = 1; g <= 3; g++) begin
            cyc(0, 0, 0, 0, 1);
            check("goal_b score", score_b, g);
            check("goal_b state", state_o, 4);
            if (g < 3) begin
                wait_state(1, 10);
                check("loser serves", server, 0);
                cyc(0, 1, 0, 0, 0);
                check("serve_a fwd", core_btn_a, 1);
                check("serve_a rally", state_o, 3);
                cyc(0, 0, 0, 0, 0);
            end
        end
        wait_state(5, 10);
        check("game_over", game_over, 1);
        check("winner", winner, 1);
        check("go core_rst", core_rst, 1);
        check("final score_b", score_b, WIN);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        check("frozen score_a", score_a, 0);
        check("frozen score_b", score_b, WIN);
        check("frozen state", state_o, 5);
        cyc(0, 1, 1, 0, 0);
        check("restart state", state_o, 0);
        check("restart score_b", score_b, 0);
        check("restart winner", winner, 0);
        check("restart game_over", game_over, 0);
        check("restart core_rst", core_rst, 1);

        // Held button gives one press; reset during goal hold.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("new serve_a", state_o, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("new rally", state_o, 3);
        cyc(0, 0, 0, 0, 0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 0, 0, 0);
            pulses += int'(core_btn_a);
        end
        cyc(0, 0, 0, 0, 0);
        pulses += int'(core_btn_a);
        check("held pulses", pulses, 1);
        cyc(0, 0, 0, 1, 1);
        check("perr again", protocol_err, 1);
        cyc(0, 0, 0, 0, 1);
        check("hold entry", state_o, 4);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("abort state", state_o, 0);
        check("abort core_rst", core_rst, 1);
        check("abort score_b", score_b, 0);
        check("abort server", server, 0);
        check("abort perr", protocol_err, 0);
        check("abort btns", {core_btn_a, core_btn_b}, 0);

        // Random play against the model.
        for (int k = 0; k < 4000; k++) begin
            logic a, b;
            a = ($urandom_range(0, 2) == 0) ? ~BTN_A : BTN_A;
            b = ($urandom_range(0, 2) == 0) ? ~BTN_B : BTN_B;
            cyc(($urandom_range(0, 599) == 0), a, b,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
